// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT bridge driver and its helpers.
//   Default clock / frequency-clamp / dead-time constants, the FSM state
//   enum, and the frequency clamp helper.
package swipt_pkg;

  localparam int unsigned CLK_HZ_DEF   = 100_000_000;
  localparam int unsigned F_MIN_DEF    = 20_000;
  localparam int unsigned F_MAX_DEF    = 200_000;
  localparam int unsigned DEAD_CYC_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_MUL,
    S_ARM
  } state_t;

  // A request of 0 Hz falls below lo and therefore maps to lo.
  function automatic logic [19:0] clamp_freq(input logic [19:0] f,
                                             input logic [19:0] lo,
                                             input logic [19:0] hi);
    if (f < lo)      return lo;
    else if (f > hi) return hi;
    else             return f;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
//   clk, rst  : clock, synchronous active-high reset (aborts a divide)
//   start     : 1-cycle pulse, loads dividend/divisor
//   dividend  : DIV_W-bit dividend
//   divisor   : DVS_W-bit divisor (must be non-zero)
//   done      : high during the cycle whose clock edge retires the last
//               quotient bit; quotient is valid from the following cycle
//   quotient  : truncated to Q_W bits
module seq_udiv #(
  parameter int unsigned DIV_W = 27,
  parameter int unsigned DVS_W = 20,
  parameter int unsigned Q_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int unsigned CW = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] q_sh;   // dividend shifts out the top, quotient in the bottom
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [DVS_W:0]   trial;

  assign trial = {rem, q_sh[DIV_W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      q_sh <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
    end else if (start) begin
      q_sh <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      cnt  <= CW'(DIV_W);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (trial >= {1'b0, dvs}) begin
        rem  <= DVS_W'(trial - {1'b0, dvs});
        q_sh <= {q_sh[DIV_W-2:0], 1'b1};
      end else begin
        rem  <= trial[DVS_W-1:0];
        q_sh <= {q_sh[DIV_W-2:0], 1'b0};
      end
    end
  end

  assign done     = (cnt == CW'(1));
  assign quotient = q_sh[Q_W-1:0];

endmodule

// File: rtl/swipt_bridge_driver.sv
// Full-bridge gate driver for the SWIPT link.
//   Turns a requested frequency (Hz) and an on-time word l (period/4096
//   units) into four gate signals with guaranteed dead time. New settings
//   are divided/multiplied into a staged config and applied at a period
//   boundary so no runt pulse is ever produced.
//   clk, rst          : clock, synchronous active-high reset
//   en                : drive enable; low forces all gates low
//   freq, l           : requested frequency / on-time word
//   SWIPT_OUT0/3      : diagonal A high/low-side gates
//   SWIPT_OUT1/2      : diagonal B high/low-side gates
//   period_cnt/on_cnt : active period / on-time in clk cycles
//   cfg_valid         : first configuration active
//   busy              : recompute in progress or pending
//   period_start      : pulse on the first cycle of each period
module swipt_bridge_driver
  import swipt_pkg::*;
#(
  parameter int unsigned CLK_HZ   = CLK_HZ_DEF,
  parameter int unsigned DIV_W    = 27,
  parameter int unsigned PER_W    = 16,
  parameter int unsigned F_MIN    = F_MIN_DEF,
  parameter int unsigned F_MAX    = F_MAX_DEF,
  parameter int unsigned DEAD_CYC = DEAD_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [19:0]      freq,
  input  logic [11:0]      l,
  output logic             SWIPT_OUT0,
  output logic             SWIPT_OUT1,
  output logic             SWIPT_OUT2,
  output logic             SWIPT_OUT3,
  output logic [PER_W-1:0] period_cnt,
  output logic [PER_W-1:0] on_cnt,
  output logic             cfg_valid,
  output logic             busy,
  output logic             period_start
);

  localparam int unsigned PROD_W = PER_W + 12;

  state_t state, state_nx;

  logic [19:0]      freq_r, acc_f;
  logic [11:0]      l_r, acc_l, lc;
  logic             boot, dirty;
  logic             accept, apply, div_start, div_done;
  logic [PER_W-1:0] div_q, q_s, on_s, cnt, half;
  logic             running, boundary;
  logic             gate_a, gate_b;
  logic [PROD_W-1:0] prod, on_full, half_q, on_max, on_sel;

  seq_udiv #(
    .DIV_W (DIV_W),
    .DVS_W (20),
    .Q_W   (PER_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (DIV_W'(CLK_HZ)),
    .divisor  (clamp_freq(freq_r, 20'(F_MIN), 20'(F_MAX))),
    .done     (div_done),
    .quotient (div_q)
  );

  // On-time scaled from l, limited so each diagonal leaves DEAD_CYC idle
  // cycles before the other one starts.
  always_comb begin
    prod    = PROD_W'(div_q) * PROD_W'(lc);
    on_full = prod >> 12;
    half_q  = PROD_W'(div_q >> 1);
    on_max  = (half_q > PROD_W'(DEAD_CYC)) ? half_q - PROD_W'(DEAD_CYC) : '0;
    on_sel  = (on_full > on_max) ? on_max : on_full;
  end

  assign running      = en & cfg_valid;
  assign boundary     = running & (cnt == period_cnt - PER_W'(1));
  assign half         = period_cnt >> 1;
  assign period_start = running & (cnt == '0);
  assign busy         = (state != S_IDLE) | dirty;

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    div_start = 1'b0;
    apply     = 1'b0;
    case (state)
      S_IDLE: if (dirty) begin
        accept    = 1'b1;
        div_start = 1'b1;
        state_nx  = S_DIV;
      end
      S_DIV:  if (div_done) state_nx = S_MUL;
      S_MUL:  state_nx = S_ARM;
      S_ARM:  if (!cfg_valid || !en || boundary) begin
        apply    = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      freq_r     <= '0;
      l_r        <= '0;
      acc_f      <= '0;
      acc_l      <= '0;
      lc         <= '0;
      boot       <= 1'b1;
      dirty      <= 1'b0;
      q_s        <= '0;
      on_s       <= '0;
      period_cnt <= '0;
      on_cnt     <= '0;
      cfg_valid  <= 1'b0;
      cnt        <= '0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
    end else begin
      state  <= state_nx;
      freq_r <= freq;
      l_r    <= l;
      boot   <= 1'b0;

      if (accept) begin
        dirty <= 1'b0;
        acc_f <= freq_r;
        acc_l <= l_r;
        lc    <= l_r;
      end else if (boot || freq_r != acc_f || l_r != acc_l) begin
        dirty <= 1'b1;
      end

      if (state == S_MUL) begin
        q_s  <= div_q;
        on_s <= PER_W'(on_sel);
      end

      // Loading on the boundary edge coincides with cnt wrapping to 0, so
      // the new period starts cleanly.
      if (apply) begin
        period_cnt <= q_s;
        on_cnt     <= on_s;
        cfg_valid  <= 1'b1;
      end

      if (running) cnt <= boundary ? '0 : cnt + PER_W'(1);
      else         cnt <= '0;

      gate_a <= running & (cnt < on_cnt);
      gate_b <= running & (cnt >= half) & (cnt < half + on_cnt);
    end
  end

  assign SWIPT_OUT0 = gate_a;
  assign SWIPT_OUT3 = gate_a;
  assign SWIPT_OUT1 = gate_b;
  assign SWIPT_OUT2 = gate_b;

endmodule

// File: tb/tb_swipt_bridge_driver.sv
module tb_swipt_bridge_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [19:0] freq = '0;
  logic [11:0] l = '0;
  logic        o0, o1, o2, o3;
  logic [15:0] period_cnt, on_cnt;
  logic        cfg_valid, busy, period_start;

  int n_vec = 0;
  int n_bad = 0;

  int m_a_first, m_a_last, m_b_first, m_b_last;
  int m_overlap, m_pair_err, m_ps_extra, m_ps_end;

  always #5 clk = ~clk;

  swipt_bridge_driver #(
    .CLK_HZ   (100_000_000),
    .DIV_W    (27),
    .PER_W    (16),
    .F_MIN    (20_000),
    .F_MAX    (200_000),
    .DEAD_CYC (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .freq         (freq),
    .l            (l),
    .SWIPT_OUT0   (o0),
    .SWIPT_OUT1   (o1),
    .SWIPT_OUT2   (o2),
    .SWIPT_OUT3   (o3),
    .period_cnt   (period_cnt),
    .on_cnt       (on_cnt),
    .cfg_valid    (cfg_valid),
    .busy         (busy),
    .period_start (period_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_period(input logic [15:0] v, input int lim, input string tag);
    for (int i = 0; i < lim && period_cnt !== v; i++) @(negedge clk);
    check(tag, period_cnt, v);
  endtask

  task automatic wait_ps(input int lim, input string tag);
    for (int i = 0; i < lim && period_start !== 1'b1; i++) @(negedge clk);
    check(tag, period_start, 1'b1);
  endtask

  task automatic wait_cfg(input int lim, input string tag);
    for (int i = 0; i < lim && cfg_valid !== 1'b1; i++) @(negedge clk);
    check(tag, cfg_valid, 1'b1);
  endtask

  // Called on the period_start sample; gates lag the counter by one cycle,
  // so sample k reflects counter value k-1.
  task automatic measure(input int p);
    m_a_first = -1; m_a_last = -1; m_b_first = -1; m_b_last = -1;
    m_overlap = 0; m_pair_err = 0; m_ps_extra = 0; m_ps_end = 0;
    for (int k = 1; k <= p; k++) begin
      @(negedge clk);
      if (o0 !== o3 || o1 !== o2) m_pair_err++;
      if (o0 === 1'b1 && o1 === 1'b1) m_overlap++;
      if (o0 === 1'b1) begin
        if (m_a_first < 0) m_a_first = k - 1;
        m_a_last = k - 1;
      end
      if (o1 === 1'b1) begin
        if (m_b_first < 0) m_b_first = k - 1;
        m_b_last = k - 1;
      end
      if (k < p && period_start === 1'b1) m_ps_extra++;
      if (k == p) m_ps_end = int'(period_start);
    end
  endtask

  task automatic check_shape(input string t, input int af, input int al,
                             input int bf, input int bl);
    check({t, "_a_first"}, m_a_first, af);
    check({t, "_a_last"},  m_a_last,  al);
    check({t, "_b_first"}, m_b_first, bf);
    check({t, "_b_last"},  m_b_last,  bl);
    check({t, "_overlap"}, m_overlap, 0);
    check({t, "_pair"},    m_pair_err, 0);
    check({t, "_ps_mid"},  m_ps_extra, 0);
    check({t, "_ps_end"},  m_ps_end, 1);
  endtask

  logic [15:0] seen[$];
  logic [15:0] last_p;
  int          gap_ab;

  initial begin
    // 1: reset state, then 35 kHz / l=200
    en = 1'b1; freq = 20'd35000; l = 12'd200;
    cycles(3);
    check("rst_gates", {o0, o1, o2, o3}, 4'b0000);
    check("rst_period", period_cnt, 0);
    check("rst_on", on_cnt, 0);
    check("rst_cfg", cfg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ps", period_start, 0);
    rst = 1'b0;
    @(negedge clk);
    check("boot_busy", busy, 1);
    wait_cfg(60, "t1_cfg_valid");
    check("t1_period", period_cnt, 2857);
    check("t1_on", on_cnt, 139);
    wait_ps(10, "t1_ps");
    measure(2857);
    check_shape("t1", 0, 138, 1428, 1566);

    // 2: on-time clamp keeps the dead time
    l = 12'd4095;
    for (int i = 0; i < 6000 && on_cnt !== 16'd1418; i++) @(negedge clk);
    check("t2_on", on_cnt, 1418);
    wait_ps(3000, "t2_ps");
    measure(2857);
    check_shape("t2", 0, 1417, 1428, 2845);
    gap_ab = m_b_first - m_a_last - 1;
    check("t2_gap_ge10", gap_ab >= 10, 1);

    // 3: frequency clamps
    freq = 20'd0;
    wait_period(16'd5000, 10000, "t3_f0_period");
    check("t3_f0_on", on_cnt, 2490);
    freq = 20'd1_000_000;
    wait_period(16'd500, 12000, "t3_fmax_period");
    check("t3_fmax_on", on_cnt, 240);
    check("t3_no_x", $isunknown({o0, o1, o2, o3, period_cnt, on_cnt, busy}), 0);

    // 4: change mid-period; old period must finish intact
    freq = 20'd35000; l = 12'd200;
    wait_period(16'd2857, 3000, "t4_period_old");
    check("t4_on_old", on_cnt, 139);
    wait_ps(3000, "t4_ps");
    cycles(1000);
    freq = 20'd50000;
    begin
      int len;
      len = 1000;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        len++;
        if (period_start === 1'b1) break;
        check("t4_period_held", period_cnt, 2857);
      end
      check("t4_old_len", len, 2857);
    end
    check("t4_period_new", period_cnt, 2000);
    measure(2000);
    check_shape("t4", 0, 96, 1000, 1096);

    // 5: two writes 5 cycles apart, both applied in order
    last_p = period_cnt;
    freq = 20'd35000;
    cycles(5);
    freq = 20'd20000;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (period_cnt !== last_p) begin
        seen.push_back(period_cnt);
        last_p = period_cnt;
      end
      if (seen.size() >= 2 && busy === 1'b0) break;
    end
    check("t5_n_changes", seen.size(), 2);
    if (seen.size() >= 2) begin
      check("t5_first", seen[0], 2857);
      check("t5_second", seen[1], 5000);
    end
    check("t5_busy", busy, 0);

    // 6: en drop mid-pulse, re-enable, then rst mid-divide
    wait_ps(6000, "t6_ps");
    cycles(100);
    check("t6_pulse_on", o0, 1);
    en = 1'b0;
    @(negedge clk);
    check("t6_en0_gates", {o0, o1, o2, o3}, 4'b0000);
    check("t6_en0_ps", period_start, 0);
    cycles(5);
    check("t6_en0_hold", {o0, o1, o2, o3}, 4'b0000);
    en = 1'b1;
    #1;
    check("t6_en1_ps", period_start, 1);
    @(negedge clk);
    check("t6_en1_gate", {o0, o3}, 2'b11);
    check("t6_en1_ps_drop", period_start, 0);
    freq = 20'd35000;
    cycles(10);
    check("t6_busy_div", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_gates", {o0, o1, o2, o3}, 4'b0000);
    check("t6_rst_period", period_cnt, 0);
    check("t6_rst_cfg", cfg_valid, 0);
    check("t6_rst_busy", busy, 0);
    rst = 1'b0;
    wait_cfg(60, "t6_cfg_again");
    check("t6_period_again", period_cnt, 2857);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
